// File: rtl/wb_rr_arbiter_if.sv
// Wishbone bundle between NUM_M masters, the round-robin arbiter and the shared slave port.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface wb_rr_arbiter_if #(
  parameter int unsigned NUM_M = 2,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32
);
  localparam int unsigned SW = DW / 8;

  logic [NUM_M-1:0]    m_cyc_in;
  logic [NUM_M-1:0]    m_stb_in;
  logic [NUM_M-1:0]    m_we_in;
  logic [NUM_M*AW-1:0] m_adr_in;
  logic [NUM_M*DW-1:0] m_dat_in;
  logic [NUM_M*SW-1:0] m_sel_in;
  logic [NUM_M-1:0]    m_ack_o;
  logic [NUM_M-1:0]    m_err_o;
  logic [DW-1:0]       m_dat_o;
  logic [NUM_M-1:0]    gnt_o;

  logic                s_cyc_o;
  logic                s_stb_o;
  logic                s_we_o;
  logic [AW-1:0]       s_adr_o;
  logic [DW-1:0]       s_dat_o;
  logic [SW-1:0]       s_sel_o;
  logic                s_ack_in;
  logic                s_err_in;
  logic [DW-1:0]       s_dat_in;

  modport slave (
    input  m_cyc_in, m_stb_in, m_we_in, m_adr_in, m_dat_in, m_sel_in,
    input  s_ack_in, s_err_in, s_dat_in,
    output m_ack_o, m_err_o, m_dat_o, gnt_o,
    output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o
  );

  modport master (
    output m_cyc_in, m_stb_in, m_we_in, m_adr_in, m_dat_in, m_sel_in,
    output s_ack_in, s_err_in, s_dat_in,
    input  m_ack_o, m_err_o, m_dat_o, gnt_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o
  );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: NUM_M masters share one slave port, granted per whole cycle,
// with a strobe watchdog that terminates stalled transfers with err.
module wb_rr_arbiter #(
  parameter int unsigned NUM_M   = 2,
  parameter int unsigned AW      = 5,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  wb_rr_arbiter_if.slave    bus
);

  localparam int unsigned SW = DW / 8;
  localparam int unsigned IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_OWNED = 1'b1
  } state_t;

  state_t          r_state;
  logic [NUM_M-1:0] r_gnt;
  logic [IW-1:0]   r_own;
  logic [IW-1:0]   r_last;
  logic [CW-1:0]   r_wd_cnt;

  logic            w_pick_vld;
  logic [IW-1:0]   w_pick;
  logic            w_own_cyc;
  logic            w_own_stb;
  logic            w_own_we;
  logic [AW-1:0]   w_own_adr;
  logic [DW-1:0]   w_own_dat;
  logic [SW-1:0]   w_own_sel;
  logic            w_to_hit;
  logic            w_stb;
  logic            w_ack;
  logic            w_err;

  // Circular search starting just after the last owner; the smallest offset wins.
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick     = r_last;
    for (int k = int'(NUM_M); k >= 1; k--) begin
      if (bus.m_cyc_in[IW'((int'(r_last) + k) % int'(NUM_M))]) begin
        w_pick_vld = 1'b1;
        w_pick     = IW'((int'(r_last) + k) % int'(NUM_M));
      end
    end
  end

  // Owner's bus signals; all zero when nothing is granted.
  always_comb begin
    w_own_cyc = 1'b0;
    w_own_stb = 1'b0;
    w_own_we  = 1'b0;
    w_own_adr = '0;
    w_own_dat = '0;
    w_own_sel = '0;
    for (int i = 0; i < int'(NUM_M); i++) begin
      if (r_gnt[i]) begin
        w_own_cyc = bus.m_cyc_in[i];
        w_own_stb = bus.m_stb_in[i];
        w_own_we  = bus.m_we_in[i];
        w_own_adr = bus.m_adr_in[i*AW +: AW];
        w_own_dat = bus.m_dat_in[i*DW +: DW];
        w_own_sel = bus.m_sel_in[i*SW +: SW];
      end
    end
  end

  always_comb begin
    w_to_hit = (TIMEOUT != 0) && (r_state == S_OWNED) && w_own_stb &&
               (r_wd_cnt == CW'(TIMEOUT));
    w_stb    = (r_state == S_OWNED) && w_own_stb && !w_to_hit;
    w_ack    = bus.s_ack_in && !bus.s_err_in && w_stb;
    w_err    = (bus.s_err_in && w_stb) || w_to_hit;
  end

  assign bus.s_cyc_o = (r_state == S_OWNED) && w_own_cyc;
  assign bus.s_stb_o = w_stb;
  assign bus.s_we_o  = w_own_we;
  assign bus.s_adr_o = w_own_adr;
  assign bus.s_dat_o = w_own_dat;
  assign bus.s_sel_o = w_own_sel;
  assign bus.m_ack_o = {NUM_M{w_ack}} & r_gnt;
  assign bus.m_err_o = {NUM_M{w_err}} & r_gnt;
  assign bus.m_dat_o = bus.s_dat_in;
  assign bus.gnt_o   = r_gnt;

  // Grant FSM: a grant lasts for the owner's whole cyc, then one idle cycle before the next.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_own   <= '0;
      r_last  <= IW'(NUM_M - 1);
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pick_vld) begin
            r_state <= S_OWNED;
            r_gnt   <= NUM_M'(1) << w_pick;
            r_own   <= w_pick;
          end
        end
        S_OWNED: begin
          if (!w_own_cyc) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_last  <= r_own;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_gnt   <= '0;
        end
      endcase
    end
  end

  // Watchdog counts cycles of an unterminated strobe; a hit drops stb, so it also clears.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_wd_cnt <= '0;
    end else if ((TIMEOUT == 0) || !w_stb || bus.s_ack_in || bus.s_err_in) begin
      r_wd_cnt <= '0;
    end else begin
      r_wd_cnt <= r_wd_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: single transfer, contention, fairness, watchdog,
// ack/err collision and mid-cycle reset, with hand-computed expectations.
module tb_wb_rr_arbiter;

  localparam int unsigned NUM_M   = 2;
  localparam int unsigned AW      = 5;
  localparam int unsigned DW      = 32;
  localparam int unsigned TIMEOUT = 16;

  logic clk_in;
  logic rst_n_in;
  int   n_chk;
  int   n_err;

  wb_rr_arbiter_if #(.NUM_M(NUM_M), .AW(AW), .DW(DW)) bus ();

  wb_rr_arbiter #(.NUM_M(NUM_M), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .bus      (bus)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic probe();
    @(negedge clk_in);
  endtask

  logic [1:0] fair_exp [7];

  initial begin
    n_chk = 0;
    n_err = 0;
    fair_exp = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};

    // Reset with everything active: outputs must stay quiet.
    rst_n_in     = 1'b0;
    bus.m_cyc_in = 2'b11;
    bus.m_stb_in = 2'b11;
    bus.m_we_in  = 2'b11;
    bus.m_adr_in = '0;
    bus.m_dat_in = '0;
    bus.m_sel_in = '0;
    bus.s_ack_in = 1'b1;
    bus.s_err_in = 1'b1;
    bus.s_dat_in = '0;
    probe();
    probe();
    chk("rst_gnt",   64'(bus.gnt_o),   64'h0);
    chk("rst_s_cyc", 64'(bus.s_cyc_o), 64'h0);
    chk("rst_s_stb", 64'(bus.s_stb_o), 64'h0);
    chk("rst_ack",   64'(bus.m_ack_o), 64'h0);
    chk("rst_err",   64'(bus.m_err_o), 64'h0);
    bus.m_cyc_in = 2'b00;
    bus.m_stb_in = 2'b00;
    bus.m_we_in  = 2'b00;
    bus.s_ack_in = 1'b0;
    bus.s_err_in = 1'b0;
    #1;
    rst_n_in = 1'b1;

    // Single master write from m0.
    tick();
    bus.m_cyc_in = 2'b01;
    bus.m_stb_in = 2'b01;
    bus.m_we_in  = 2'b01;
    bus.m_adr_in = {5'h00, 5'h04};
    bus.m_dat_in = {32'h0, 32'hA5A5_0001};
    bus.m_sel_in = {4'h0, 4'hF};
    probe();
    chk("single_gnt_lat", 64'(bus.gnt_o),   64'h0);
    chk("single_cyc_lat", 64'(bus.s_cyc_o), 64'h0);
    tick();
    probe();
    chk("single_gnt",   64'(bus.gnt_o),   64'h1);
    chk("single_s_cyc", 64'(bus.s_cyc_o), 64'h1);
    chk("single_s_stb", 64'(bus.s_stb_o), 64'h1);
    chk("single_s_we",  64'(bus.s_we_o),  64'h1);
    chk("single_s_adr", 64'(bus.s_adr_o), 64'h04);
    chk("single_s_dat", 64'(bus.s_dat_o), 64'hA5A5_0001);
    chk("single_s_sel", 64'(bus.s_sel_o), 64'hF);
    chk("single_noack", 64'(bus.m_ack_o), 64'h0);
    bus.s_ack_in = 1'b1;
    bus.s_dat_in = 32'hDEAD_BEEF;
    #1;
    chk("single_ack",   64'(bus.m_ack_o), 64'h1);
    chk("single_noerr", 64'(bus.m_err_o), 64'h0);
    chk("single_rdat",  64'(bus.m_dat_o), 64'hDEAD_BEEF);
    tick();
    bus.m_cyc_in = 2'b00;
    bus.m_stb_in = 2'b00;
    bus.m_we_in  = 2'b00;
    bus.s_ack_in = 1'b0;
    probe();
    chk("single_hold_gnt", 64'(bus.gnt_o),   64'h1);
    chk("single_drop_cyc", 64'(bus.s_cyc_o), 64'h0);
    chk("single_idle_adr", 64'(bus.s_adr_o), 64'h04);
    tick();
    probe();
    chk("single_release", 64'(bus.gnt_o),   64'h0);
    chk("idle_adr_zero",  64'(bus.s_adr_o), 64'h0);

    // Contention right after reset: m0 first, idle cycle, then m1.
    rst_n_in = 1'b0;
    #1;
    rst_n_in = 1'b1;
    tick();
    bus.m_cyc_in = 2'b11;
    bus.m_stb_in = 2'b11;
    bus.m_adr_in = {5'h11, 5'h02};
    probe();
    chk("cont_lat", 64'(bus.gnt_o), 64'h0);
    tick();
    probe();
    chk("cont_gnt_m0", 64'(bus.gnt_o),   64'h1);
    chk("cont_adr_m0", 64'(bus.s_adr_o), 64'h02);
    bus.s_ack_in = 1'b1;
    #1;
    chk("cont_ack_m0_only", 64'(bus.m_ack_o), 64'h1);
    tick();
    bus.m_cyc_in = 2'b10;
    bus.m_stb_in = 2'b10;
    bus.s_ack_in = 1'b0;
    probe();
    chk("cont_m0_hold", 64'(bus.gnt_o),   64'h1);
    chk("cont_no_ack",  64'(bus.m_ack_o), 64'h0);
    tick();
    probe();
    chk("cont_idle_gap", 64'(bus.gnt_o), 64'h0);
    tick();
    probe();
    chk("cont_gnt_m1", 64'(bus.gnt_o),   64'h2);
    chk("cont_adr_m1", 64'(bus.s_adr_o), 64'h11);
    chk("cont_cyc_m1", 64'(bus.s_cyc_o), 64'h1);
    bus.s_ack_in = 1'b1;
    #1;
    chk("cont_ack_m1", 64'(bus.m_ack_o), 64'h2);
    tick();
    bus.m_cyc_in = 2'b00;
    bus.m_stb_in = 2'b00;
    bus.s_ack_in = 1'b0;
    tick();
    probe();
    chk("cont_release", 64'(bus.gnt_o), 64'h0);

    // Fairness: both request; each owner gives up cyc once granted, then re-requests.
    tick();
    bus.m_cyc_in = 2'b11;
    for (int i = 0; i < 7; i++) begin
      tick();
      bus.m_cyc_in = 2'b11 & ~fair_exp[i];
      probe();
      chk($sformatf("fair_gnt_%0d", i), 64'(bus.gnt_o), 64'(fair_exp[i]));
    end
    tick();
    bus.m_cyc_in = 2'b00;
    tick();
    tick();
    probe();
    chk("fair_release", 64'(bus.gnt_o), 64'h0);

    // Watchdog: m0 strobes, slave never terminates.
    tick();
    bus.m_cyc_in = 2'b01;
    bus.m_stb_in = 2'b01;
    bus.m_adr_in = {5'h00, 5'h08};
    tick();
    probe();
    chk("to_stb_rise", 64'(bus.s_stb_o), 64'h1);
    chk("to_err_0",    64'(bus.m_err_o), 64'h0);
    for (int k = 1; k < 16; k++) begin
      tick();
      probe();
      chk($sformatf("to_quiet_%0d", k), 64'({bus.m_err_o, bus.m_ack_o, bus.s_stb_o}), 64'h1);
    end
    tick();
    probe();
    chk("to_err_hit", 64'(bus.m_err_o), 64'h1);
    chk("to_stb_low", 64'(bus.s_stb_o), 64'h0);
    chk("to_no_ack",  64'(bus.m_ack_o), 64'h0);
    chk("to_cyc_kept", 64'(bus.s_cyc_o), 64'h1);
    tick();
    probe();
    chk("to_err_once",   64'(bus.m_err_o), 64'h0);
    chk("to_stb_back",   64'(bus.s_stb_o), 64'h1);
    chk("to_gnt_kept",   64'(bus.gnt_o),   64'h1);
    tick();
    bus.m_cyc_in = 2'b00;
    bus.m_stb_in = 2'b00;
    tick();
    probe();
    chk("to_release", 64'(bus.gnt_o), 64'h0);

    // Ack and err together: err wins. Termination without stb is dropped.
    tick();
    bus.m_cyc_in = 2'b10;
    bus.m_stb_in = 2'b10;
    bus.m_we_in  = 2'b10;
    tick();
    probe();
    chk("ae_gnt_m1", 64'(bus.gnt_o), 64'h2);
    bus.s_ack_in = 1'b1;
    bus.s_err_in = 1'b1;
    #1;
    chk("ae_err", 64'(bus.m_err_o), 64'h2);
    chk("ae_ack", 64'(bus.m_ack_o), 64'h0);
    bus.s_err_in = 1'b0;
    bus.m_stb_in = 2'b00;
    #1;
    chk("nostb_ack_drop", 64'(bus.m_ack_o), 64'h0);
    chk("nostb_s_stb",    64'(bus.s_stb_o), 64'h0);
    bus.m_stb_in = 2'b10;
    #1;
    chk("stb_ack_m1", 64'(bus.m_ack_o), 64'h2);

    // Reset in the middle of m1's strobe aborts at once; m0 wins afterwards.
    rst_n_in = 1'b0;
    #1;
    chk("mid_rst_gnt",   64'(bus.gnt_o),   64'h0);
    chk("mid_rst_s_cyc", 64'(bus.s_cyc_o), 64'h0);
    chk("mid_rst_ack",   64'(bus.m_ack_o), 64'h0);
    chk("mid_rst_err",   64'(bus.m_err_o), 64'h0);
    bus.s_ack_in = 1'b0;
    bus.m_cyc_in = 2'b11;
    bus.m_stb_in = 2'b00;
    #1;
    rst_n_in = 1'b1;
    tick();
    probe();
    chk("post_rst_m0_first", 64'(bus.gnt_o), 64'h1);
    tick();
    bus.m_cyc_in = 2'b00;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
